// File: rtl/tx_ptt_if.sv
// Signal bundle between the PTT sequencer and its surroundings (host
// control, TX IQ FIFO, transmitter datapath).
//
//   ptt_req        host PTT request (asynchronous to clk)
//   fifo_level     TX IQ FIFO fill level
//   fifo_empty     TX IQ FIFO empty
//   sample_req     one-cycle interpolator sample request
//   tx_enable      transmitter PTT / DAC gate
//   tr_relay       T/R relay drive, 1 = antenna to TX
//   pa_enable      PA bias enable
//   ramp_gain      unsigned Q1.15 envelope gain, 0x8000 = unity
//   underflow      sticky underflow-abort flag
//   prefill_fault  sticky prefill-timeout flag
//   state          current sequencer state for status readback
//
// master: the sequencer. slave: the environment driving its inputs.
interface tx_ptt_if #(
  parameter int LVL_W = 12
);
  logic             ptt_req;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_empty;
  logic             sample_req;
  logic             tx_enable;
  logic             tr_relay;
  logic             pa_enable;
  logic [15:0]      ramp_gain;
  logic             underflow;
  logic             prefill_fault;
  logic [2:0]       state;

  modport master (
    input  ptt_req, fifo_level, fifo_empty, sample_req,
    output tx_enable, tr_relay, pa_enable, ramp_gain, underflow,
           prefill_fault, state
  );

  modport slave (
    output ptt_req, fifo_level, fifo_empty, sample_req,
    input  tx_enable, tr_relay, pa_enable, ramp_gain, underflow,
           prefill_fault, state
  );
endinterface

// File: rtl/tx_ptt_sequencer.sv
// Transmit/receive sequencer. Turns the host PTT request into an ordered
// key sequence (FIFO prefill, relay to TX, DAC/PA enable with gain ramp-up)
// and the reverse on release, aborting on sustained FIFO underflow.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    tx_ptt_if.master (see the interface file for the signal list)
module tx_ptt_sequencer #(
  parameter int LVL_W           = 12,
  parameter int PREFILL_LEVEL   = 512,
  parameter int PREFILL_TIMEOUT = 7680000,
  parameter int RELAY_DLY       = 76800,
  parameter int RAMP_STEP       = 512,
  parameter int UNDERFLOW_MAX   = 16
) (
  input logic      clk,
  input logic      reset,
  tx_ptt_if.master bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PREFILL   = 3'd1;
  localparam logic [2:0] S_RELAY_ON  = 3'd2;
  localparam logic [2:0] S_RAMP_UP   = 3'd3;
  localparam logic [2:0] S_TX        = 3'd4;
  localparam logic [2:0] S_RAMP_DOWN = 3'd5;
  localparam logic [2:0] S_RELAY_OFF = 3'd6;

  localparam int TMR_MAX = (PREFILL_TIMEOUT > RELAY_DLY) ? PREFILL_TIMEOUT : RELAY_DLY;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int UCNT_W  = $clog2(UNDERFLOW_MAX + 1);

  // The timer is loaded with N-1 on entry and the exit fires on the cycle it
  // reads zero, so a state with an N-cycle budget lasts exactly N cycles.
  localparam logic [TMR_W-1:0]  PREFILL_LOAD = TMR_W'(PREFILL_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  RELAY_LOAD   = TMR_W'(RELAY_DLY - 1);
  localparam logic [UCNT_W-1:0] UCNT_LAST    = UCNT_W'(UNDERFLOW_MAX - 1);
  localparam logic [LVL_W-1:0]  LEVEL_MIN    = LVL_W'(PREFILL_LEVEL);
  localparam logic [15:0]       GAIN_UNITY   = 16'h8000;
  localparam logic [15:0]       GAIN_STEP    = 16'(RAMP_STEP);

  logic              sync1;
  logic              ptt_s;
  logic [2:0]        cur;
  logic [2:0]        nxt;
  logic [TMR_W-1:0]  timer;
  logic [15:0]       gain;
  logic [15:0]       gain_nxt;
  logic [15:0]       gain_up;
  logic [15:0]       gain_dn;
  logic [16:0]       gain_sum;
  logic [UCNT_W-1:0] ucnt;
  logic              uf_flag;
  logic              pf_flag;
  logic              abort_lock;

  logic timer_done;
  logic level_ok;
  logic in_tx_window;
  logic abort_hit;
  logic prefill_expire;
  logic start_key;
  logic tx_on;

  assign timer_done   = (timer == '0);
  assign level_ok     = (bus.fifo_level >= LEVEL_MIN);
  assign in_tx_window = (cur == S_RAMP_UP) || (cur == S_TX);

  // Abort fires on the sample request that would take the run of empty
  // requests to UNDERFLOW_MAX.
  assign abort_hit      = bus.sample_req && bus.fifo_empty && in_tx_window &&
                          (ucnt == UCNT_LAST);
  assign prefill_expire = (cur == S_PREFILL) && !level_ok && ptt_s && timer_done;
  assign start_key      = (cur == S_IDLE) && ptt_s && !abort_lock;

  // Saturating ramp arithmetic; a 17-bit sum keeps the carry visible.
  assign gain_sum = {1'b0, gain} + {1'b0, GAIN_STEP};
  assign gain_up  = (gain_sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_sum[15:0];
  assign gain_dn  = (gain > GAIN_STEP) ? (gain - GAIN_STEP) : 16'h0000;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    nxt      = cur;
    gain_nxt = gain;
    case (cur)
      S_IDLE: begin
        if (start_key) nxt = S_PREFILL;
      end
      S_PREFILL: begin
        if (level_ok)        nxt = S_RELAY_ON;
        else if (!ptt_s)     nxt = S_IDLE;
        else if (timer_done) nxt = S_IDLE;
      end
      S_RELAY_ON: begin
        // A release beats a coincident timer expiry.
        if (!ptt_s)          nxt = S_RELAY_OFF;
        else if (timer_done) nxt = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (bus.sample_req) gain_nxt = gain_up;
        // Release or abort wins over reaching unity in the same cycle.
        if (!ptt_s || abort_hit)        nxt = S_RAMP_DOWN;
        else if (gain_nxt == GAIN_UNITY) nxt = S_TX;
      end
      S_TX: begin
        gain_nxt = GAIN_UNITY;
        if (!ptt_s || abort_hit) nxt = S_RAMP_DOWN;
      end
      S_RAMP_DOWN: begin
        if (bus.sample_req) gain_nxt = gain_dn;
        // Leave on the same edge the gain lands on zero, so tx_enable drops
        // in the first cycle the gain reads zero.
        if (gain_nxt == 16'h0000) nxt = S_RELAY_OFF;
      end
      S_RELAY_OFF: begin
        if (timer_done) nxt = S_IDLE;
      end
      default: begin
        nxt      = S_IDLE;
        gain_nxt = 16'h0000;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order in the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      ptt_s      <= 1'b0;
      cur        <= S_IDLE;
      timer      <= '0;
      gain       <= 16'h0000;
      ucnt       <= '0;
      uf_flag    <= 1'b0;
      pf_flag    <= 1'b0;
      abort_lock <= 1'b0;
    end else begin
      sync1 <= bus.ptt_req;
      ptt_s <= sync1;
      cur   <= nxt;
      gain  <= gain_nxt;

      // One shared down-counter, reloaded on every state change.
      if (nxt != cur) timer <= (nxt == S_PREFILL) ? PREFILL_LOAD : RELAY_LOAD;
      else if (!timer_done) timer <= timer - 1'b1;

      if (start_key) begin
        ucnt <= '0;
      end else if (bus.sample_req) begin
        if (!bus.fifo_empty) ucnt <= '0;
        else if (in_tx_window) ucnt <= ucnt + 1'b1;
      end

      if (start_key) begin
        uf_flag <= 1'b0;
        pf_flag <= 1'b0;
      end
      if (prefill_expire) begin
        pf_flag    <= 1'b1;
        abort_lock <= 1'b1;
      end
      if (abort_hit) begin
        uf_flag    <= 1'b1;
        abort_lock <= 1'b1;
      end
      // The host must drop PTT before a faulted sequence can be rekeyed.
      if ((cur == S_IDLE) && !ptt_s) abort_lock <= 1'b0;
    end
  end

  assign tx_on             = (cur == S_RAMP_UP) || (cur == S_TX) || (cur == S_RAMP_DOWN);
  assign bus.tx_enable     = tx_on;
  assign bus.pa_enable     = tx_on;
  assign bus.tr_relay      = (cur == S_RELAY_ON) || tx_on || (cur == S_RELAY_OFF);
  assign bus.ramp_gain     = gain;
  assign bus.underflow     = uf_flag;
  assign bus.prefill_fault = pf_flag;
  assign bus.state         = cur;

endmodule

// File: tb/tb_tx_ptt_sequencer.sv
// Bench for tx_ptt_sequencer: directed scenarios with literal expectations,
// then randomized stimulus, with every cycle compared against a behavioural
// model of the sequencing rules.
module tb_tx_ptt_sequencer;
  localparam int LVL_W     = 12;
  localparam int P_LEVEL   = 4;
  localparam int P_TIMEOUT = 50;
  localparam int P_DLY     = 10;
  localparam int P_STEP    = 8192;
  localparam int P_UMAX    = 4;
  localparam int UNITY     = 32768;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  tx_ptt_if #(.LVL_W(LVL_W)) bus ();

  tx_ptt_sequencer #(
    .LVL_W(LVL_W), .PREFILL_LEVEL(P_LEVEL), .PREFILL_TIMEOUT(P_TIMEOUT),
    .RELAY_DLY(P_DLY), .RAMP_STEP(P_STEP), .UNDERFLOW_MAX(P_UMAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases follow the documented state numbering; m_cnt counts cycles
  // already spent in the current phase.
  bit m_valid;
  bit m_s1, m_ps;
  int m_st, m_cnt, m_gain, m_ucnt;
  bit m_uf, m_pf, m_lock;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; m_s1 = 0; m_ps = 0; m_st = 0; m_cnt = 0;
      m_gain = 0; m_ucnt = 0; m_uf = 0; m_pf = 0; m_lock = 0;
    end else if (m_valid) begin
      bit ps;
      bit abort;
      int ns;
      int ng;
      ps = m_ps;
      m_ps = m_s1;
      m_s1 = bus.ptt_req;
      ns = m_st;
      ng = m_gain;
      abort = 0;
      if (bus.sample_req) begin
        if (!bus.fifo_empty) m_ucnt = 0;
        else if (m_st == 3 || m_st == 4) begin
          m_ucnt++;
          if (m_ucnt == P_UMAX) begin abort = 1; m_uf = 1; m_lock = 1; end
        end
      end
      case (m_st)
        0: if (!ps) m_lock = 0;
           else if (!m_lock) begin m_uf = 0; m_pf = 0; m_ucnt = 0; ns = 1; end
        1: if (int'(bus.fifo_level) >= P_LEVEL) ns = 2;
           else if (!ps) ns = 0;
           else if (m_cnt + 1 >= P_TIMEOUT) begin m_pf = 1; m_lock = 1; ns = 0; end
        2: if (!ps) ns = 6;
           else if (m_cnt + 1 >= P_DLY) ns = 3;
        3: begin
             if (bus.sample_req) ng = (m_gain + P_STEP > UNITY) ? UNITY : m_gain + P_STEP;
             if (!ps || abort) ns = 5;
             else if (ng == UNITY) ns = 4;
           end
        4: if (!ps || abort) ns = 5;
        5: begin
             if (bus.sample_req) ng = (m_gain > P_STEP) ? m_gain - P_STEP : 0;
             if (ng == 0) ns = 6;
           end
        6: if (m_cnt + 1 >= P_DLY) ns = 0;
        default: ;
      endcase
      m_cnt  = (ns != m_st) ? 0 : m_cnt + 1;
      m_st   = ns;
      m_gain = ng;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_state",     32'(bus.state),         32'(m_st));
      check("model_tr_relay",  32'(bus.tr_relay),      (m_st >= 2 && m_st <= 6) ? 32'd1 : 32'd0);
      check("model_tx_enable", 32'(bus.tx_enable),     (m_st >= 3 && m_st <= 5) ? 32'd1 : 32'd0);
      check("model_pa_enable", 32'(bus.pa_enable),     (m_st >= 3 && m_st <= 5) ? 32'd1 : 32'd0);
      check("model_gain",      32'(bus.ramp_gain),     32'(m_gain));
      check("model_underflow", 32'(bus.underflow),     32'(m_uf));
      check("model_pf_fault",  32'(bus.prefill_fault), 32'(m_pf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sample();
    @(negedge clk); bus.sample_req = 1'b1;
    @(negedge clk); bus.sample_req = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string name);
    int n = 0;
    while (bus.state !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.state), 32'(target));
  endtask

  initial begin
    int n;
    bit empty_heavy;
    reset = 1'b1;
    bus.ptt_req = 1'b0; bus.fifo_level = '0; bus.fifo_empty = 1'b0; bus.sample_req = 1'b0;
    tick(3);
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_relay", 32'(bus.tr_relay), 32'd0);
    check("reset_gain",  32'(bus.ramp_gain), 32'd0);
    reset = 1'b0;
    tick(2);

    // Key/unkey timing.
    bus.fifo_level = 12'd8; bus.ptt_req = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (bus.tr_relay !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check("key_to_relay_clk", 32'(n), 32'd3);
    n = 0;
    while (bus.tx_enable !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    check("relay_to_tx_clk", 32'(n), 32'd10);
    pulse_sample(); check("ramp_g1", 32'(bus.ramp_gain), 32'd8192);
    pulse_sample(); check("ramp_g2", 32'(bus.ramp_gain), 32'd16384);
    pulse_sample(); check("ramp_g3", 32'(bus.ramp_gain), 32'd24576);
    pulse_sample(); check("ramp_g4", 32'(bus.ramp_gain), 32'd32768);
    check("tx_state", 32'(bus.state), 32'd4);
    bus.ptt_req = 1'b0;
    tick(4);
    pulse_sample(); check("down_g1", 32'(bus.ramp_gain), 32'd24576);
    pulse_sample(); check("down_g2", 32'(bus.ramp_gain), 32'd16384);
    pulse_sample(); check("down_g3", 32'(bus.ramp_gain), 32'd8192);
    pulse_sample(); check("down_g4", 32'(bus.ramp_gain), 32'd0);
    check("down_tx_off", 32'(bus.tx_enable), 32'd0);
    n = 0;
    while (bus.tr_relay !== 1'b0 && n < 30) begin @(posedge clk); #1; n++; end
    check("unkey_relay_clk", 32'(n), 32'd10);
    check("unkey_idle", 32'(bus.state), 32'd0);

    // Prefill wait.
    @(negedge clk);
    bus.fifo_level = 12'd2; bus.ptt_req = 1'b1;
    wait_state(3'd1, 10, "prefill_enter");
    tick(10);
    check("prefill_hold_state", 32'(bus.state), 32'd1);
    check("prefill_hold_relay", 32'(bus.tr_relay), 32'd0);
    bus.fifo_level = 12'd4;
    tick(1);
    check("prefill_level_met", 32'(bus.state), 32'd2);
    bus.ptt_req = 1'b0;
    wait_state(3'd0, 30, "prefill_release_idle");

    // Prefill timeout and rekey lockout.
    bus.fifo_level = 12'd0; bus.ptt_req = 1'b1;
    wait_state(3'd1, 10, "timeout_enter");
    n = 0;
    while (bus.state !== 3'd0 && n < 80) begin @(posedge clk); #1; n++; end
    check("timeout_clk", 32'(n), 32'd50);
    check("timeout_fault", 32'(bus.prefill_fault), 32'd1);
    bus.fifo_level = 12'd8;
    tick(20);
    check("timeout_locked", 32'(bus.state), 32'd0);
    bus.ptt_req = 1'b0;
    tick(5);
    bus.ptt_req = 1'b1;
    wait_state(3'd2, 20, "rekey_after_release");
    check("rekey_fault_cleared", 32'(bus.prefill_fault), 32'd0);

    // Underflow abort from TX.
    wait_state(3'd3, 20, "uf_ramp_up");
    repeat (4) pulse_sample();
    check("uf_in_tx", 32'(bus.state), 32'd4);
    bus.fifo_empty = 1'b1;
    repeat (3) pulse_sample();
    check("uf_not_yet", 32'(bus.underflow), 32'd0);
    pulse_sample();
    check("uf_flag", 32'(bus.underflow), 32'd1);
    check("uf_ramp_down", 32'(bus.state), 32'd5);
    repeat (4) pulse_sample();
    check("uf_gain_zero", 32'(bus.ramp_gain), 32'd0);
    wait_state(3'd0, 20, "uf_idle");
    tick(20);
    check("uf_no_rekey", 32'(bus.state), 32'd0);
    check("uf_relay_off", 32'(bus.tr_relay), 32'd0);
    check("uf_sticky", 32'(bus.underflow), 32'd1);

    // Early release during ramp-up.
    bus.fifo_empty = 1'b0; bus.ptt_req = 1'b0;
    tick(5);
    bus.ptt_req = 1'b1;
    wait_state(3'd3, 40, "early_ramp_up");
    pulse_sample(); pulse_sample();
    check("early_gain", 32'(bus.ramp_gain), 32'd16384);
    bus.ptt_req = 1'b0;
    tick(4);
    check("early_state", 32'(bus.state), 32'd5);
    pulse_sample(); check("early_down1", 32'(bus.ramp_gain), 32'd8192);
    pulse_sample(); check("early_down2", 32'(bus.ramp_gain), 32'd0);
    check("early_relay_off", 32'(bus.state), 32'd6);
    wait_state(3'd0, 30, "early_idle");

    // Reset mid-TX.
    bus.ptt_req = 1'b1;
    wait_state(3'd3, 40, "rst_ramp_up");
    repeat (4) pulse_sample();
    check("rst_in_tx", 32'(bus.state), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_tx", 32'(bus.tx_enable), 32'd0);
    check("rst_relay", 32'(bus.tr_relay), 32'd0);
    check("rst_gain", 32'(bus.ramp_gain), 32'd0);
    reset = 1'b0; bus.ptt_req = 1'b0;
    tick(5);

    // Randomized traffic, checked by the model every cycle.
    empty_heavy = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus.sample_req = !bus.sample_req && ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 149) == 0) bus.ptt_req = !bus.ptt_req;
      if ($urandom_range(0, 39) == 0) bus.fifo_level = 12'($urandom_range(0, 8));
      if ($urandom_range(0, 99) == 0) empty_heavy = !empty_heavy;
      bus.fifo_empty = empty_heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 2999) == 0);
    end
    reset = 1'b0; bus.sample_req = 1'b0;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_ptt_sequencer.md
Name: tx_ptt_sequencer

Overview:
- Sequences transmit/receive switching around the TX datapath (FIR interpolator, CIC, CORDIC, DAC gate).
- Turns the host PTT request into an ordered sequence: FIFO prefill, T/R relay switching, DAC enable and gain ramp-up, then the reverse on release.
- Aborts transmission safely on sustained TX FIFO underflow.
- Sits between the host control interface, the TX IQ FIFO and the transmitter datapath; drives its PTT input and a gain multiplier.

Parameters:
- LVL_W, 12, width of FIFO fill-level input.
- PREFILL_LEVEL, 512, minimum FIFO words before keying.
- PREFILL_TIMEOUT, 7680000, clk cycles allowed in PREFILL (100 ms at 76.8 MHz).
- RELAY_DLY, 76800, clk cycles for relay settle on key and on unkey (1 ms).
- RAMP_STEP, 512, gain change per sample_req during ramps (64 samples, about 1.33 ms at 48 kHz).
- UNDERFLOW_MAX, 16, consecutive empty sample requests that trigger an abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ptt_req  in  1  host PTT request; asynchronous, synchronised internally.
- fifo_level  in  LVL_W  TX IQ FIFO fill level, synchronous to clk.
- fifo_empty  in  1  TX IQ FIFO empty.
- sample_req  in  1  one-cycle pulse when the interpolator requests a new input sample (48 kHz).
- tx_enable  out  1  drives the transmitter PTT (DAC gate).
- tr_relay  out  1  T/R relay drive; 1 = antenna to TX.
- pa_enable  out  1  PA bias enable.
- ramp_gain  out  16  unsigned Q1.15 envelope gain; 0x8000 = unity.
- underflow  out  1  sticky underflow-abort flag.
- prefill_fault  out  1  sticky prefill-timeout flag.
- state  out  3  current FSM state, for status readback.

Behaviour:
Reset and synchronisation:
- Reset forces state=IDLE (0) and all outputs to 0 on the next clk, including tr_relay and the sticky flags. Relay hot-switch on reset is accepted.
- ptt_req passes through a 2-FF synchroniser; the FSM acts on ptt_s, 2 clk after the input.

States (encoding 0..6) and transitions:
- IDLE(0): all drives 0. Leaves on ptt_s=1 with abort_lock=0: clears underflow and prefill_fault, loads the timer, goes to PREFILL.
- PREFILL(1): all drives 0.
  - fifo_level >= PREFILL_LEVEL: go to RELAY_ON.
  - ptt_s=0: go to IDLE.
  - Timer expires after PREFILL_TIMEOUT cycles: set prefill_fault, set abort_lock, go to IDLE.
- RELAY_ON(2): tr_relay=1.
  - After RELAY_DLY cycles: go to RAMP_UP.
  - ptt_s=0: go to RELAY_OFF (timer reloaded).
- RAMP_UP(3): tr_relay=tx_enable=pa_enable=1.
  - Each sample_req adds RAMP_STEP to gain, saturating at 0x8000.
  - Gain reaches 0x8000: go to TX.
  - ptt_s=0: go to RAMP_DOWN, starting from the current gain.
- TX(4): gain held at 0x8000. ptt_s=0 or underflow abort: go to RAMP_DOWN.
- RAMP_DOWN(5): drives still 1. Each sample_req subtracts RAMP_STEP, clamping at 0. When gain=0: tx_enable=pa_enable=0 on the same cycle and go to RELAY_OFF.
- RELAY_OFF(6): tr_relay=1 for RELAY_DLY cycles, then 0, then go to IDLE. ptt_s is ignored in this state.

Gain rules:
- Gain changes only on sample_req cycles, so it is stable across one sample period.
- Gain is 0 in states 0, 1, 2 and 6.

Underflow:
- A counter increments on sample_req with fifo_empty=1, only in RAMP_UP and TX.
- It clears on sample_req with fifo_empty=0, and on entry to PREFILL.
- Reaching UNDERFLOW_MAX sets underflow and abort_lock. In RAMP_UP it forces RAMP_DOWN; in TX it forces RAMP_DOWN.
- abort_lock clears only when ptt_s=0 in IDLE, so the host must release PTT before rekeying.

Simultaneous events:
- ptt_s falling in the same cycle as a timer expiry in RELAY_ON: ptt_s wins (go to RELAY_OFF).
- Gain saturation and ptt_s=0 in the same cycle in RAMP_UP: go to RAMP_DOWN.

Timers and invariants:
- One shared down-counter, wide enough for max(PREFILL_TIMEOUT, RELAY_DLY). It is reloaded on every state entry.
- tr_relay never changes in a cycle where tx_enable=1.

Test Plan:
- Key/unkey timing (RELAY_DLY=10, RAMP_STEP=8192, PREFILL_LEVEL=4): fifo_level=8, ptt_req=1.
  - Required: tr_relay rises 3 clk after ptt_req (2-FF sync + PREFILL check).
  - tx_enable rises 10 clk after tr_relay.
  - ramp_gain steps 8192, 16384, 24576, 32768 on successive sample_req; state=4.
  - ptt_req=0: gain steps down to 0, tx_enable falls, tr_relay falls 10 clk later, state=0.
- Prefill wait: fifo_level=2, ptt_req=1 → state stays 1 with tr_relay=0. Raise fifo_level to 4 → state goes to 2.
- Prefill timeout (PREFILL_TIMEOUT=50): fifo_level=0, ptt_req held high →
  - prefill_fault=1 and state=0 after 50 clk.
  - Re-entry is blocked until ptt_req is released and reasserted.
- Underflow (UNDERFLOW_MAX=4): in TX, fifo_empty=1 for 4 sample_req →
  - underflow=1, gain ramps to 0, relay releases.
  - Holding ptt_req=1 does not rekey.
- Early release: drop ptt_req in RAMP_UP at gain=16384 → gain descends 8192 then 0 with no overshoot; RELAY_OFF follows.
- Reset mid-TX: assert reset in state 4 → next clk all outputs 0, state=0.
